// File: rtl/ev22_seq_pkg.sv
// ev22_seq_pkg: shared types and constants for the EV22 register-operation sequencer.
//   seq_state_e  : sequencer FSM state encoding
//   instr_t      : instruction word layout {opcode, dest, sel_a, sel_b}
//   OP_*         : ALU opcodes (OP_CMP produces flags only, so it never writes back)
//   GPR_MAX, R32, R33, WREG_IDX : register index constants used by the legality check
package ev22_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StRead,
        StExec,
        StWriteback,
        StIllegal,
        StTimeout
    } seq_state_e;

    typedef struct packed {
        logic [3:0] opcode;
        logic [5:0] dest;
        logic [4:0] sel_a;
        logic [5:0] sel_b;
    } instr_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
    localparam logic [3:0] OP_CMP = 4'h8;

    localparam logic [5:0] GPR_MAX  = 6'd27;
    localparam logic [5:0] R32      = 6'd32;
    localparam logic [5:0] R33      = 6'd33;
    localparam logic [5:0] WREG_IDX = 6'd34;

endpackage

// File: rtl/seq_reg_check.sv
// seq_reg_check: combinational legality check of the register indices of one instruction.
//   sel_a [4:0] in  : read-mux A index, legal 0..GPR_MAX
//   sel_b [5:0] in  : read-mux B index, legal 0..GPR_MAX or WREG_IDX
//   dest  [5:0] in  : write-back index, legal 0..GPR_MAX, R32, R33 or WREG_IDX
//   a_ok / b_ok / d_ok out : per-field legal flags
module seq_reg_check
    import ev22_seq_pkg::*;
(
    input  logic [4:0] sel_a,
    input  logic [5:0] sel_b,
    input  logic [5:0] dest,
    output logic       a_ok,
    output logic       b_ok,
    output logic       d_ok
);

    always_comb begin
        a_ok = ({1'b0, sel_a} <= GPR_MAX);
        b_ok = (sel_b <= GPR_MAX) || (sel_b == WREG_IDX);
        d_ok = (dest <= GPR_MAX) || (dest == R32) || (dest == R33) || (dest == WREG_IDX);
    end

endmodule

// File: rtl/regfile_op_sequencer.sv
// regfile_op_sequencer: multi-cycle control FSM sequencing one register-to-register operation
// at a time: accept, decode/check indices, operand read, ALU execute (with timeout), write-back.
// Optional feature macro: SEQ_PERF_CNT_EN adds saturating op_count / stall_count outputs.
//   clk, reset (sync, active-high)
//   instr_valid/instr_ready/instr[20:0] : instruction handshake {opcode, dest, selA, selB}
//   flush                              : abort operation in DECODE/READ/EXEC
//   Sel_A[4:0], Sel_B[5:0], updateBlock: operand read-mux control
//   alu_op[3:0], alu_start, alu_done   : ALU control
//   wr_en, wr_addr[5:0]                : register-file write port
//   op_done, illegal, timeout          : one-cycle status pulses
//   op_count[15:0], stall_count[15:0]  : perf counters (SEQ_PERF_CNT_EN only)
module regfile_op_sequencer
    import ev22_seq_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ALU_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [20:0] instr,
    input  logic        flush,
    output logic [4:0]  Sel_A,
    output logic [5:0]  Sel_B,
    output logic        updateBlock,
    output logic [3:0]  alu_op,
    output logic        alu_start,
    input  logic        alu_done,
    output logic        wr_en,
    output logic [5:0]  wr_addr,
    output logic        op_done,
    output logic        illegal,
    output logic        timeout
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [15:0] op_count,
    output logic [15:0] stall_count
`endif
);

    if (DATA_W < 1 || ALU_TIMEOUT < 1 || ALU_TIMEOUT > 255) begin : g_param_check
        $error("regfile_op_sequencer: DATA_W must be >= 1 and ALU_TIMEOUT within 1..255");
    end

    localparam logic [7:0] TimeoutCnt = 8'(ALU_TIMEOUT);

    seq_state_e state_q, state_d;
    instr_t     instr_q;
    logic [7:0] exec_cnt_q;   // EXEC cycles elapsed; 0 marks the alu_start cycle
    logic       exec_first;
    logic       accept;
    logic       a_ok, b_ok, d_ok;

    assign exec_first = (exec_cnt_q == 8'd0);
    assign accept     = instr_valid && instr_ready;

    seq_reg_check u_reg_check (
        .sel_a (instr_q.sel_a),
        .sel_b (instr_q.sel_b),
        .dest  (instr_q.dest),
        .a_ok  (a_ok),
        .b_ok  (b_ok),
        .d_ok  (d_ok)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction latch and EXEC wait counter
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q    <= '0;
            exec_cnt_q <= 8'd0;
        end else begin
            if (accept) begin
                instr_q <= instr;
            end
            if (state_q == StExec) begin
                exec_cnt_q <= exec_cnt_q + 8'd1;
            end else begin
                exec_cnt_q <= 8'd0;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (instr_valid) state_d = StDecode;
            end
            StDecode: begin
                if (flush)                   state_d = StIdle;
                else if (a_ok && b_ok && d_ok) state_d = StRead;
                else                         state_d = StIllegal;
            end
            StRead: begin
                state_d = flush ? StIdle : StExec;
            end
            StExec: begin
                // flush beats a coincident alu_done; done is not sampled in the start cycle
                if (flush)                           state_d = StIdle;
                else if (!exec_first && alu_done)    state_d = StWriteback;
                else if (exec_cnt_q == TimeoutCnt)   state_d = StTimeout;
            end
            StWriteback, StIllegal, StTimeout: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        instr_ready = 1'b0;
        updateBlock = 1'b0;
        alu_start   = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = 6'd0;
        op_done     = 1'b0;
        illegal     = 1'b0;
        timeout     = 1'b0;
        Sel_A       = 5'd0;
        Sel_B       = 6'd0;
        alu_op      = 4'd0;
        unique case (state_q)
            StIdle: begin
                instr_ready = 1'b1;
            end
            StRead: begin
                Sel_A       = instr_q.sel_a;
                Sel_B       = instr_q.sel_b;
                alu_op      = instr_q.opcode;
                updateBlock = !flush;
            end
            StExec: begin
                Sel_A     = instr_q.sel_a;
                Sel_B     = instr_q.sel_b;
                alu_op    = instr_q.opcode;
                alu_start = exec_first && !flush;
            end
            StWriteback: begin
                Sel_A   = instr_q.sel_a;
                Sel_B   = instr_q.sel_b;
                alu_op  = instr_q.opcode;
                wr_en   = (instr_q.opcode != OP_CMP);
                wr_addr = instr_q.dest;
                op_done = 1'b1;
            end
            StIllegal: begin
                illegal = 1'b1;
            end
            StTimeout: begin
                timeout = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef SEQ_PERF_CNT_EN
    logic [15:0] op_count_q;
    logic [15:0] stall_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            op_count_q    <= 16'd0;
            stall_count_q <= 16'd0;
        end else begin
            if (op_done && (op_count_q != 16'hFFFF)) begin
                op_count_q <= op_count_q + 16'd1;
            end
            if ((state_q == StExec) && !alu_done && (stall_count_q != 16'hFFFF)) begin
                stall_count_q <= stall_count_q + 16'd1;
            end
        end
    end

    assign op_count    = op_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Scoreboard bench for regfile_op_sequencer: a reference model pushes the expected pulse
// sequence (cycle-stamped) per instruction; a negedge monitor pops and compares.
module tb_regfile_op_sequencer;
    import ev22_seq_pkg::*;

    localparam int T = 15;
    localparam int KUB = 0;  // updateBlock
    localparam int KST = 1;  // alu_start
    localparam int KWB = 2;  // op_done / write-back
    localparam int KIL = 3;  // illegal
    localparam int KTO = 4;  // timeout

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic [20:0] instr = '0;
    logic        flush = 1'b0;
    logic        alu_done = 1'b0;
    logic        instr_ready, updateBlock, alu_start, wr_en, op_done, illegal, timeout;
    logic [4:0]  Sel_A;
    logic [5:0]  Sel_B, wr_addr;
    logic [3:0]  alu_op;
`ifdef SEQ_PERF_CNT_EN
    logic [15:0] op_count, stall_count;
`endif

    regfile_op_sequencer #(.DATA_W(16), .ALU_TIMEOUT(T)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .flush       (flush),
        .Sel_A       (Sel_A),
        .Sel_B       (Sel_B),
        .updateBlock (updateBlock),
        .alu_op      (alu_op),
        .alu_start   (alu_start),
        .alu_done    (alu_done),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .op_done     (op_done),
        .illegal     (illegal),
        .timeout     (timeout)
`ifdef SEQ_PERF_CNT_EN
        ,
        .op_count    (op_count),
        .stall_count (stall_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;
        int         cyc;
        logic [4:0] sa;
        logic [5:0] sb;
        logic [3:0] op;
        logic       we;
        logic [5:0] dest;
    } ev_t;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic push(input int kind, input int c, input logic [20:0] ins);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.op   = ins[20:17];
        e.dest = ins[16:11];
        e.sa   = ins[10:6];
        e.sb   = ins[5:0];
        e.we   = (ins[20:17] != OP_CMP);
        exp_q.push_back(e);
    endtask

    task automatic take(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_pulse: kind %0d at cycle %0d, expected no pulse", kind, cyc);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", kind, e.kind);
        chk("event_cycle", cyc, e.cyc);
        if (kind == KUB || kind == KST || kind == KWB) begin
            chk("Sel_A", 32'(Sel_A), 32'(e.sa));
            chk("Sel_B", 32'(Sel_B), 32'(e.sb));
            chk("alu_op", 32'(alu_op), 32'(e.op));
        end
        if (kind == KWB) begin
            chk("wr_en", 32'(wr_en), 32'(e.we));
            if (e.we) chk("wr_addr", 32'(wr_addr), 32'(e.dest));
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (wr_en) chk("wr_en_implies_op_done", 32'(op_done), 1);
            if (updateBlock) take(KUB);
            if (alu_start)   take(KST);
            if (op_done)     take(KWB);
            if (illegal)     take(KIL);
            if (timeout)     take(KTO);
        end
    end

    task automatic check_idle_outputs(input string name);
        chk(name, 32'({instr_ready, updateBlock, alu_start, wr_en, op_done, illegal, timeout,
                       Sel_A, Sel_B, wr_addr, alu_op}), 32'({1'b1, 27'd0}));
    endtask

    // One instruction. k = cycles from alu_start to alu_done (k > T: never done).
    // f = flush offset from accept cycle (0: none).
    task automatic do_op(input logic [20:0] ins, input int k, input int f);
        int  t, endo, last_exec, cut, fdrive;
        int  a, b, d;
        bit  legal;
        a = int'(ins[10:6]);
        b = int'(ins[5:0]);
        d = int'(ins[16:11]);
        legal = (a <= 27) && (b <= 27 || b == 34) && (d <= 27 || d == 32 || d == 33 || d == 34);
        chk("instr_ready_idle", 32'(instr_ready), 1);
        t = cyc;
        if (!legal) begin
            cut    = (f == 1) ? 1 : 0;
            fdrive = cut;
            if (cut == 0) push(KIL, t + 2, ins);
            endo = (cut != 0) ? 2 : 3;
        end else begin
            last_exec = (k <= T) ? 3 + k : 3 + T;
            cut       = (f >= 1 && f <= last_exec) ? f : 0;
            // a flush landing on the write-back cycle is driven but must be ignored
            fdrive    = (cut != 0 || (k <= T && f == 4 + k)) ? f : 0;
            if (cut == 0 || 2 < cut) push(KUB, t + 2, ins);
            if (cut == 0 || 3 < cut) push(KST, t + 3, ins);
            if (cut == 0) push((k <= T) ? KWB : KTO, t + 4 + ((k <= T) ? k : T), ins);
            endo = (cut != 0) ? cut + 1 : last_exec + 2;
        end
        instr_valid = 1'b1;
        instr       = ins;
        flush       = 1'b0;
        alu_done    = 1'b0;
        for (int o = 1; o < endo; o++) begin
            @(posedge clk);
            #1;
            if (o == 1) chk("instr_ready_busy", 32'(instr_ready), 0);
            instr_valid = 1'($urandom);
            instr       = 21'($urandom);
            flush       = (o == fdrive);
            alu_done    = (o <= 3) ? 1'($urandom) : (legal && k <= T && o == 3 + k);
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        flush       = 1'b0;
        alu_done    = 1'b0;
    endtask

    function automatic logic [20:0] rnd_instr();
        logic [3:0] op;
        logic [4:0] a;
        logic [5:0] b, d;
        int r;
        op = 4'($urandom);
        a  = ($urandom % 6 == 0) ? 5'($urandom) : 5'($urandom_range(0, 27));
        r  = int'($urandom % 6);
        b  = (r == 0) ? 6'($urandom) : (r == 1) ? 6'd34 : 6'($urandom_range(0, 27));
        r  = int'($urandom % 6);
        d  = (r == 0) ? 6'($urandom) : (r == 1) ? 6'($urandom_range(32, 34))
                                                : 6'($urandom_range(0, 27));
        return {op, d, a, b};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, f, r;
        logic [20:0] ins;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle_outputs("reset_state");
`ifdef SEQ_PERF_CNT_EN
        chk("op_count_reset", 32'(op_count), 0);
        chk("stall_count_reset", 32'(stall_count), 0);
`endif
        // Directed cases
        do_op({OP_ADD, 6'd5, 5'd1, 6'd2}, 1, 0);        // minimum latency
        do_op({OP_SUB, 6'd34, 5'd3, 6'd34}, 2, 0);      // selB/dest = WREG_IDX
        do_op({OP_ADD, 6'd4, 5'd28, 6'd2}, 1, 0);       // illegal selA
        do_op({OP_ADD, 6'd4, 5'd1, 6'd30}, 1, 0);       // illegal selB
        do_op({OP_ADD, 6'd29, 5'd1, 6'd2}, 1, 0);       // illegal dest
        do_op({OP_AND, 6'd7, 5'd2, 6'd3}, T + 1, 0);    // timeout
        do_op({OP_ADD, 6'd8, 5'd2, 6'd3}, 2, 5);        // flush with alu_done
        do_op({OP_OR, 6'd9, 5'd4, 6'd5}, 1, 0);         // accepted normally afterwards
        do_op({OP_CMP, 6'd10, 5'd6, 6'd7}, 3, 0);       // no write for compare
        do_op({OP_XOR, 6'd11, 5'd7, 6'd8}, 1, 5);       // flush in WRITEBACK ignored
        do_op({OP_ADD, 6'd32, 5'd27, 6'd27}, T, 0);     // bounds; done on last wait cycle
        do_op({OP_ADD, 6'd33, 5'd0, 6'd0}, 1, 1);       // flush in DECODE
        do_op({OP_ADD, 6'd1, 5'd0, 6'd1}, 1, 2);        // flush in READ
        // Randomized
        for (int n = 0; n < 60; n++) begin
            ins = rnd_instr();
            r   = int'($urandom % 8);
            k   = (r == 0) ? T + 1 : int'($urandom_range(1, (r == 1) ? T : 4));
            f   = ($urandom % 4 == 0) ? int'($urandom_range(1, 10)) : 0;
            do_op(ins, k, f);
        end
        // Reset while in EXEC
        ins = {OP_ADD, 6'd3, 5'd1, 6'd1};
        push(KUB, cyc + 2, ins);
        push(KST, cyc + 3, ins);
        instr_valid = 1'b1;
        instr       = ins;
        for (int o = 1; o <= 5; o++) begin
            @(posedge clk);
            #1;
            instr_valid = 1'b0;
            if (o == 5) reset = 1'b1;
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle_outputs("after_exec_reset");
`ifdef SEQ_PERF_CNT_EN
        chk("op_count_after_reset", 32'(op_count), 0);
        chk("stall_count_after_reset", 32'(stall_count), 0);
`endif
        do_op({OP_ADD, 6'd12, 5'd1, 6'd2}, 1, 0);
        do_op({OP_SUB, 6'd13, 5'd3, 6'd4}, 2, 0);
        do_op({OP_CMP, 6'd14, 5'd5, 6'd6}, 1, 0);
`ifdef SEQ_PERF_CNT_EN
        chk("op_count_three_ops", 32'(op_count), 3);
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
